// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: issues one SD command frame through sd_cmd_if and collects its optional R48 response
module sd_cmd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  resp_type,
    input  logic [5:0]  cmd_gap,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [47:0] resp_data,
    output logic        write_strb,
    output logic        write_no_crc_sig,
    output logic [7:0]  write_bits,
    output logic [5:0]  write_delay,
    output logic [31:0] data_towrite,
    input  logic        more_data_towrite,
    input  logic        write_data_ack,
    input  logic        read_ready,
    input  logic        read_crc_err,
    input  logic [47:0] data_read,
    input  logic        ncr_timeout
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] WORD1 = 3'd2;
    localparam logic [2:0] LAST  = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    logic [2:0]  r_state;
    logic [5:0]  r_index;
    logic [31:0] r_arg;
    logic [1:0]  r_rtype;
    logic [5:0]  r_gap;
    logic [1:0]  r_status;
    logic [47:0] r_resp;
    logic [7:0]  r_bits;
    logic [31:0] r_data;
    logic        w_has_resp;
    logic [1:0]  w_resp_status;
    assign w_has_resp       = (r_rtype == 2'd1) || (r_rtype == 2'd2);
    assign w_resp_status    = (r_rtype != 2'd1) ? 2'd0 :
                              read_crc_err ? 2'd1 :
                              (data_read[45:40] != r_index) ? 2'd3 : 2'd0;
    assign busy             = (r_state != IDLE) && (r_state != DONE);
    assign done             = r_state == DONE;
    assign write_strb       = r_state == START;
    assign write_no_crc_sig = 1'b0;
    assign write_bits       = r_bits;
    assign write_delay      = r_gap;
    assign data_towrite     = r_data;
    assign status           = r_status;
    assign resp_data        = r_resp;
    // command sequencing: latch request, send header then argument, then wait for response or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_index  <= '0;
            r_arg    <= '0;
            r_rtype  <= '0;
            r_gap    <= '0;
            r_status <= '0;
            r_resp   <= '0;
            r_bits   <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_start) begin
                    r_index <= cmd_index;
                    r_arg   <= cmd_arg;
                    r_rtype <= resp_type;
                    r_gap   <= cmd_gap;
                    r_bits  <= 8'd40;
                    r_data  <= {2'b01, cmd_index, 24'h0};
                    r_state <= START;
                end
                START: r_state <= WORD1;
                WORD1: if (write_data_ack && more_data_towrite) begin
                    r_data  <= r_arg;
                    r_state <= LAST;
                end
                LAST: if (write_data_ack) begin
                    if (!w_has_resp) r_status <= 2'd0;
                    r_state <= w_has_resp ? RESP : DONE;
                end
                RESP: if (read_ready) begin
                    r_resp   <= data_read;
                    r_status <= w_resp_status;
                    r_state  <= DONE;
                end else if (ncr_timeout) begin
                    r_status <= 2'd2;
                    r_state  <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb_sd_cmd_seq: directed checks of command issue, response status decoding, timeout and reset abort
module tb_sd_cmd_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic [1:0]  resp_type = '0;
    logic [5:0]  cmd_gap = '0;
    logic        busy, done, write_strb, write_no_crc_sig;
    logic [1:0]  status;
    logic [47:0] resp_data;
    logic [7:0]  write_bits;
    logic [5:0]  write_delay;
    logic [31:0] data_towrite;
    logic        more_data_towrite = 1'b0;
    logic        write_data_ack = 1'b0;
    logic        read_ready = 1'b0;
    logic        read_crc_err = 1'b0;
    logic [47:0] data_read = '0;
    logic        ncr_timeout = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    sd_cmd_seq dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .resp_type(resp_type), .cmd_gap(cmd_gap),
        .busy(busy), .done(done), .status(status), .resp_data(resp_data),
        .write_strb(write_strb), .write_no_crc_sig(write_no_crc_sig),
        .write_bits(write_bits), .write_delay(write_delay), .data_towrite(data_towrite),
        .more_data_towrite(more_data_towrite), .write_data_ack(write_data_ack),
        .read_ready(read_ready), .read_crc_err(read_crc_err), .data_read(data_read),
        .ncr_timeout(ncr_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " status"}, 64'(status), 64'd0);
        chk({tag, " resp_data"}, 64'(resp_data), 64'd0);
        chk({tag, " strb"}, 64'(write_strb), 64'd0);
        chk({tag, " nocrc"}, 64'(write_no_crc_sig), 64'd0);
        chk({tag, " bits"}, 64'(write_bits), 64'd0);
        chk({tag, " delay"}, 64'(write_delay), 64'd0);
        chk({tag, " data"}, 64'(data_towrite), 64'd0);
    endtask

    // issue a command and acknowledge both words; leaves the DUT in RESP or DONE
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                           input logic [5:0] gap, input bit poke);
        cmd_start = 1'b1; cmd_index = idx; cmd_arg = arg; resp_type = rt; cmd_gap = gap;
        step();
        cmd_start = 1'b0;
        chk("start strb", 64'(write_strb), 64'd1);
        chk("start bits", 64'(write_bits), 64'd40);
        chk("start data", 64'(data_towrite), 64'({2'b01, idx, 24'h0}));
        chk("start busy", 64'(busy), 64'd1);
        chk("start delay", 64'(write_delay), 64'(gap));
        chk("start nocrc", 64'(write_no_crc_sig), 64'd0);
        step();
        chk("word1 strb", 64'(write_strb), 64'd0);
        if (poke) begin
            cmd_start = 1'b1; cmd_index = ~idx; cmd_arg = ~arg; cmd_gap = ~gap; resp_type = 2'd0;
            step();
            cmd_start = 1'b0;
            chk("poke strb", 64'(write_strb), 64'd0);
            chk("poke busy", 64'(busy), 64'd1);
            chk("poke delay", 64'(write_delay), 64'(gap));
        end
        write_data_ack = 1'b1; more_data_towrite = 1'b1;
        step();
        write_data_ack = 1'b0; more_data_towrite = 1'b0;
        chk("arg data", 64'(data_towrite), 64'(arg));
        chk("arg strb", 64'(write_strb), 64'd0);
        write_data_ack = 1'b1;
        step();
        write_data_ack = 1'b0;
    endtask

    // drive one response cycle from the sd_cmd_if side and check the completion
    task automatic respond(input string tag, input logic rdy, input logic tmo, input logic crc,
                           input logic [47:0] dat, input logic [1:0] exp_st, input logic [47:0] exp_rd);
        chk({tag, " resp busy"}, 64'(busy), 64'd1);
        chk({tag, " resp done"}, 64'(done), 64'd0);
        read_ready = rdy; ncr_timeout = tmo; read_crc_err = crc; data_read = dat;
        step();
        read_ready = 1'b0; ncr_timeout = 1'b0; read_crc_err = 1'b0;
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " status"}, 64'(status), 64'(exp_st));
        chk({tag, " resp_data"}, 64'(resp_data), 64'(exp_rd));
        step();
        chk({tag, " done clr"}, 64'(done), 64'd0);
        chk({tag, " status hold"}, 64'(status), 64'(exp_st));
    endtask

    initial begin
        step(); step();
        chk_reset_state("reset");
        reset = 1'b0;
        step();
        // CMD0, no response
        run_cmd(6'd0, 32'h0, 2'd0, 6'd5, 1'b0);
        chk("cmd0 done", 64'(done), 64'd1);
        chk("cmd0 busy", 64'(busy), 64'd0);
        chk("cmd0 status", 64'(status), 64'd0);
        step();
        chk("cmd0 idle done", 64'(done), 64'd0);
        // CMD17 R1 good, CRC error, index mismatch
        run_cmd(6'd17, 32'h00001000, 2'd1, 6'd8, 1'b0);
        respond("cmd17 ok", 1'b1, 1'b0, 1'b0, 48'h1100000900AB, 2'd0, 48'h1100000900AB);
        run_cmd(6'd17, 32'h00001000, 2'd1, 6'd8, 1'b0);
        respond("cmd17 crc", 1'b1, 1'b0, 1'b1, 48'h1200000900AB, 2'd1, 48'h1200000900AB);
        run_cmd(6'd17, 32'h00001000, 2'd1, 6'd8, 1'b0);
        respond("cmd17 idx", 1'b1, 1'b0, 1'b0, 48'h1200000900AB, 2'd3, 48'h1200000900AB);
        // ACMD41 R3 ignores crc and index
        run_cmd(6'd41, 32'h40FF8000, 2'd2, 6'd3, 1'b0);
        respond("acmd41", 1'b1, 1'b0, 1'b1, 48'h3F80FF8000FF, 2'd0, 48'h3F80FF8000FF);
        // stray read_ready while idle must not touch resp_data
        read_ready = 1'b1; data_read = 48'h111111111111;
        step();
        read_ready = 1'b0;
        chk("idle rdy resp_data", 64'(resp_data), 64'h3F80FF8000FF);
        chk("idle rdy done", 64'(done), 64'd0);
        // timeout keeps prior response
        run_cmd(6'd17, 32'h00002000, 2'd1, 6'd8, 1'b0);
        respond("timeout", 1'b0, 1'b1, 1'b0, 48'h1100000900AB, 2'd2, 48'h3F80FF8000FF);
        // ready and timeout together: ready wins
        run_cmd(6'd17, 32'h00002000, 2'd1, 6'd8, 1'b0);
        respond("rdy+tmo", 1'b1, 1'b1, 1'b0, 48'h1100000900AB, 2'd0, 48'h1100000900AB);
        // resp_type 3 behaves as no response
        run_cmd(6'd9, 32'hDEADBEEF, 2'd3, 6'd1, 1'b0);
        chk("rt3 done", 64'(done), 64'd1);
        chk("rt3 status", 64'(status), 64'd0);
        chk("rt3 resp_data", 64'(resp_data), 64'h1100000900AB);
        step();
        // cmd_start during WORD1 ignored; latched index still 17 so response checks against it
        run_cmd(6'd17, 32'hA5A50F0F, 2'd1, 6'd12, 1'b1);
        respond("poke", 1'b1, 1'b0, 1'b0, 48'h1100000900AB, 2'd0, 48'h1100000900AB);
        // reset while in RESP aborts without done
        run_cmd(6'd17, 32'h00003000, 2'd1, 6'd7, 1'b0);
        reset = 1'b1;
        step();
        chk_reset_state("abort");
        reset = 1'b0;
        cmd_start = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h1AA; resp_type = 2'd1; cmd_gap = 6'd2;
        step();
        cmd_start = 1'b0;
        chk("post-reset strb", 64'(write_strb), 64'd1);
        chk("post-reset done", 64'(done), 64'd0);
        chk("post-reset data", 64'(data_towrite), 64'h48000000);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
